// File: rtl/regfile_mp_pkg.sv
// Shared constants and types for the multi-port register file and its scoreboard.
package regfile_mp_pkg;

    localparam int XLEN_DEF = 64;
    localparam int NREG_DEF = 32;
    localparam int NRD_DEF  = 2;
    localparam int NWR_DEF  = 1;
    localparam int REG_X0   = 0;

    typedef enum logic [1:0] {
        SRC_ZERO   = 2'd0,
        SRC_BYPASS = 2'd1,
        SRC_STORE  = 2'd2
    } rd_src_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-producer bits: issue sets, a clearing write retires, set wins.
module regfile_scoreboard
    import regfile_mp_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int NWR  = NWR_DEF,
    parameter int AW   = $clog2(NREG)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NWR-1:0]     wr_en_i,
    input  logic [NWR*AW-1:0]  wr_addr_i,
    input  logic [NWR-1:0]     wr_clr_i,
    input  logic               iss_en_i,
    input  logic [AW-1:0]      iss_rd_i,
    output logic [NREG-1:0]    clr_vec_o,
    output logic [NREG-1:0]    busy_vec_o
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] clr_vec;

    always_comb begin
        clr_vec = '0;
        for (int p = 0; p < NWR; p++) begin
            if (wr_en_i[p] && wr_clr_i[p]) begin
                clr_vec[wr_addr_i[p*AW +: AW]] = 1'b1;
            end
        end
        clr_vec[REG_X0] = 1'b0;
    end

    // A fresh issue replaces the retiring producer, so set has priority over clear.
    always_comb begin
        busy_d = busy_q;
        for (int r = 1; r < NREG; r++) begin
            if (iss_en_i && (iss_rd_i == AW'(r))) begin
                busy_d[r] = 1'b1;
            end else if (clr_vec[r]) begin
                busy_d[r] = 1'b0;
            end
        end
        busy_d[REG_X0] = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign clr_vec_o  = clr_vec;
    assign busy_vec_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: NRD bypassed combinational reads, NWR prioritised
// writes, hardwired-zero x0 and an integrated busy scoreboard for RAW hazard detection.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NRD  = NRD_DEF,
    parameter int NWR  = NWR_DEF,
    parameter int AW   = $clog2(NREG)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NRD*AW-1:0]    rs_addr_i,
    output logic [NRD*XLEN-1:0]  rs_data_o,
    output logic [NRD-1:0]       rs_busy_o,
    input  logic [NWR-1:0]       wr_en_i,
    input  logic [NWR*AW-1:0]    wr_addr_i,
    input  logic [NWR*XLEN-1:0]  wr_data_i,
    input  logic [NWR-1:0]       wr_clr_i,
    input  logic                 iss_en_i,
    input  logic [AW-1:0]        iss_rd_i,
    output logic [NREG-1:0]      busy_vec_o
);

    if (NRD < 1 || NRD > 8) begin : g_bad_nrd
        $error("regfile_mp: NRD must be 1..8");
    end
    if (NWR < 1 || NWR > 4) begin : g_bad_nwr
        $error("regfile_mp: NWR must be 1..4");
    end
    if (NREG < 2 || (NREG & (NREG - 1)) != 0) begin : g_bad_nreg
        $error("regfile_mp: NREG must be a power of two >= 2");
    end

    logic [XLEN-1:0] mem_q [1:NREG-1];
    logic [XLEN-1:0] mem_d [1:NREG-1];
    logic [NREG-1:0] busy_vec;
    logic [NREG-1:0] clr_vec;

    // Ports are applied in ascending order so the highest index lands last and wins.
    always_comb begin
        mem_d = mem_q;
        for (int p = 0; p < NWR; p++) begin
            if (wr_en_i[p] && (wr_addr_i[p*AW +: AW] != AW'(REG_X0))) begin
                mem_d[wr_addr_i[p*AW +: AW]] = wr_data_i[p*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 1; r < NREG; r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    regfile_scoreboard #(
        .NREG (NREG),
        .NWR  (NWR),
        .AW   (AW)
    ) u_sb (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wr_en_i    (wr_en_i),
        .wr_addr_i  (wr_addr_i),
        .wr_clr_i   (wr_clr_i),
        .iss_en_i   (iss_en_i),
        .iss_rd_i   (iss_rd_i),
        .clr_vec_o  (clr_vec),
        .busy_vec_o (busy_vec)
    );

    assign busy_vec_o = busy_vec;

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] byp_data;
        logic [XLEN-1:0] data;
        rd_src_e         src;

        assign addr = rs_addr_i[i*AW +: AW];

        always_comb begin
            src      = SRC_STORE;
            byp_data = '0;
            if (addr == AW'(REG_X0)) begin
                src = SRC_ZERO;
            end else begin
                for (int p = 0; p < NWR; p++) begin
                    if (wr_en_i[p] && (wr_addr_i[p*AW +: AW] == addr)) begin
                        src      = SRC_BYPASS;
                        byp_data = wr_data_i[p*XLEN +: XLEN];
                    end
                end
            end
        end

        always_comb begin
            case (src)
                SRC_ZERO:   data = '0;
                SRC_BYPASS: data = byp_data;
                default:    data = mem_q[addr];
            endcase
        end

        assign rs_data_o[i*XLEN +: XLEN] = data;
        // A retiring write this cycle already hides the busy bit from the reader.
        assign rs_busy_o[i] = (addr != AW'(REG_X0)) && busy_vec[addr] && !clr_vec[addr];
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (NRD=2, NWR=2): reset, bypass, x0, priority, scoreboard.
module tb_regfile_mp;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int AW   = 5;

    logic                clk;
    logic                rst;
    logic [NRD*AW-1:0]   rs_addr;
    logic [NRD*XLEN-1:0] rs_data;
    logic [NRD-1:0]      rs_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic [NWR-1:0]      wr_clr;
    logic                iss_en;
    logic [AW-1:0]       iss_rd;
    logic [NREG-1:0]     busy_vec;

    int n_checks = 0;
    int n_errs   = 0;

    regfile_mp #(
        .XLEN (XLEN),
        .NREG (NREG),
        .NRD  (NRD),
        .NWR  (NWR),
        .AW   (AW)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .rs_addr_i  (rs_addr),
        .rs_data_o  (rs_data),
        .rs_busy_o  (rs_busy),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .wr_clr_i   (wr_clr),
        .iss_en_i   (iss_en),
        .iss_rd_i   (iss_rd),
        .busy_vec_o (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        wr_en  = '0;
        wr_addr = '0;
        wr_data = '0;
        wr_clr = '0;
        iss_en = 1'b0;
        iss_rd = '0;
    endtask

    task automatic wr(input int p, input logic [AW-1:0] a, input logic [63:0] d, input logic clr);
        wr_en[p]              = 1'b1;
        wr_addr[p*AW +: AW]   = a;
        wr_data[p*XLEN +: XLEN] = d;
        wr_clr[p]             = clr;
    endtask

    task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rs_addr = {a1, a0};
    endtask

    function automatic logic [63:0] rdat(input int i);
        return rs_data[i*XLEN +: XLEN];
    endfunction

    initial begin
        rst = 1'b1;
        idle();
        rd(5'd5, 5'd6);
        repeat (2) @(negedge clk);
        #1;
        check("rst_rd5", rdat(0), 64'h0);
        check("rst_busy", 64'(busy_vec), 64'h0);
        check("rst_rsbusy", 64'(rs_busy), 64'h0);

        // Load x5 and mark it busy, then reset asynchronously.
        @(negedge clk);
        rst = 1'b0;
        wr(0, 5'd5, 64'hDEAD, 1'b0);
        iss_en = 1'b1;
        iss_rd = 5'd5;
        @(negedge clk);
        idle();
        #1;
        check("pre_rst_rd5", rdat(0), 64'hDEAD);
        check("pre_rst_busy5", 64'(busy_vec[5]), 64'h1);
        check("pre_rst_rsbusy", 64'(rs_busy[0]), 64'h1);
        rst = 1'b1;
        #1;
        check("async_rst_rd5", rdat(0), 64'h0);
        check("async_rst_busy", 64'(busy_vec), 64'h0);
        wr(1, 5'd6, 64'h77, 1'b0);
        #1;
        check("rst_bypass_rd6", rdat(1), 64'h77);
        @(negedge clk);
        idle();
        rst = 1'b0;
        #1;
        check("rst_discard_rd6", rdat(1), 64'h0);

        // Same-cycle bypass on both ports, then from storage.
        @(negedge clk);
        wr(0, 5'd3, 64'h1234, 1'b0);
        rd(5'd3, 5'd3);
        #1;
        check("byp_p0", rdat(0), 64'h1234);
        check("byp_p1", rdat(1), 64'h1234);
        @(negedge clk);
        idle();
        #1;
        check("store_p0", rdat(0), 64'h1234);
        check("store_p1", rdat(1), 64'h1234);

        // x0 ignores writes and issues.
        @(negedge clk);
        wr(0, 5'd0, 64'hFFFF, 1'b1);
        iss_en = 1'b1;
        iss_rd = 5'd0;
        rd(5'd0, 5'd3);
        #1;
        check("x0_byp", rdat(0), 64'h0);
        check("x0_rsbusy", 64'(rs_busy[0]), 64'h0);
        @(negedge clk);
        idle();
        #1;
        check("x0_rd", rdat(0), 64'h0);
        check("x0_busyvec", 64'(busy_vec), 64'h0);

        // Highest write port wins.
        @(negedge clk);
        wr(0, 5'd7, 64'hAA, 1'b0);
        wr(1, 5'd7, 64'hBB, 1'b0);
        rd(5'd7, 5'd3);
        #1;
        check("prio_byp", rdat(0), 64'hBB);
        @(negedge clk);
        idle();
        #1;
        check("prio_store", rdat(0), 64'hBB);
        check("prio_other", rdat(1), 64'h1234);

        // Scoreboard lifecycle on x9.
        @(negedge clk);
        iss_en = 1'b1;
        iss_rd = 5'd9;
        rd(5'd9, 5'd9);
        #1;
        check("sb_n_rsbusy", 64'(rs_busy[0]), 64'h0);
        @(negedge clk);
        idle();
        #1;
        check("sb_n1_rsbusy", 64'(rs_busy[0]), 64'h1);
        check("sb_n1_vec9", 64'(busy_vec[9]), 64'h1);
        @(negedge clk);
        #1;
        check("sb_n2_rsbusy", 64'(rs_busy[1]), 64'h1);
        @(negedge clk);
        wr(1, 5'd9, 64'h99, 1'b1);
        #1;
        check("sb_n3_rsbusy", 64'(rs_busy), 64'h0);
        check("sb_n3_data", rdat(0), 64'h99);
        check("sb_n3_vec9", 64'(busy_vec[9]), 64'h1);
        @(negedge clk);
        idle();
        #1;
        check("sb_n4_vec9", 64'(busy_vec[9]), 64'h0);
        check("sb_n4_data", rdat(1), 64'h99);

        // Write without clr keeps busy; clr without wr_en is ignored.
        @(negedge clk);
        iss_en = 1'b1;
        iss_rd = 5'd11;
        rd(5'd11, 5'd9);
        @(negedge clk);
        idle();
        wr(0, 5'd11, 64'h5, 1'b0);
        #1;
        check("noclr_rsbusy", 64'(rs_busy[0]), 64'h1);
        check("noclr_data", rdat(0), 64'h5);
        @(negedge clk);
        idle();
        wr_clr[0] = 1'b1;
        wr_addr[0 +: AW] = 5'd11;
        #1;
        check("noclr_vec11", 64'(busy_vec[11]), 64'h1);
        check("clr_noen_rsbusy", 64'(rs_busy[0]), 64'h1);
        @(negedge clk);
        idle();
        #1;
        check("clr_noen_vec11", 64'(busy_vec[11]), 64'h1);

        // Set/clear collision on x4: set wins, data still written.
        @(negedge clk);
        iss_en = 1'b1;
        iss_rd = 5'd4;
        rd(5'd4, 5'd11);
        @(negedge clk);
        idle();
        iss_en = 1'b1;
        iss_rd = 5'd4;
        wr(0, 5'd4, 64'h44, 1'b1);
        #1;
        check("coll_pre_vec4", 64'(busy_vec[4]), 64'h1);
        check("coll_rsbusy", 64'(rs_busy[0]), 64'h0);
        @(negedge clk);
        idle();
        #1;
        check("coll_vec4", 64'(busy_vec[4]), 64'h1);
        check("coll_data", rdat(0), 64'h44);
        check("coll_rsbusy_next", 64'(rs_busy), 64'h3);
        check("coll_vec_all", 64'(busy_vec), 64'h0000_0810);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
